if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
Instruction-fetch sequencer for the IF stage. It owns the PC register and drives an SRAM-like instruction bus with a req/addr_ok/data_ok handshake. It applies jump/branch redirects and presents one fetched instruction at a time to ID, holding it while the pipeline stalls. It replaces the free-running PC update with a handshake-aware controller.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
FETCH_STEP, 4, PC increment per sequential fetch (bytes)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  ID cannot accept; an instruction is accepted in a cycle with if_valid=1 and stall=0
branch  in  1  branch redirect request (1-cycle pulse)
jump  in  1  jump redirect request (1-cycle pulse); has priority over branch
branch_addr  in  32  branch target
jump_addr  in  32  jump target
inst_req  out  1  bus request
inst_addr  out  32  bus address; stable while inst_req=1
inst_addr_ok  in  1  bus accepted address this cycle
inst_data_ok  in  1  read data valid this cycle
inst_rdata  in  32  read data
if_valid  out  1  if_pc/if_inst valid for ID
if_pc  out  32  PC of presented instruction
if_inst  out  32  presented instruction

Behaviour:
- Registers: pc (next fetch address), tgt (saved redirect target), discard (flag), output register {if_valid, if_pc, if_inst}, 2-bit state.
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, tgt=0, discard=0, inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0.
- redirect = jump|branch; target = jump ? jump_addr : branch_addr.
- IDLE: first clock after reset release -> REQ. Redirects in IDLE load pc=target.
- REQ: inst_req=1, inst_addr=pc. On inst_addr_ok -> WAIT. A redirect sets discard=1 and tgt=target without changing inst_addr. A redirect in the same cycle as addr_ok behaves the same.
- WAIT: inst_req=0. On inst_data_ok:
  - If discard=1 or redirect this cycle: drop the data, pc=(redirect ? target : tgt), discard=0, go to REQ.
  - Otherwise: if_valid=1, if_pc=pc, if_inst=inst_rdata, pc=pc+FETCH_STEP (mod 2^32, wraps from FFFF_FFFC to 0000_0000), go to OUT.
  - A redirect without data_ok sets discard=1 and tgt=target. A later redirect overwrites tgt.
- OUT: if_valid=1; outputs held constant while stall=1.
  - Redirect (with or without stall): if_valid=0, pc=target, go to REQ. The ID stage only redirects after the delay-slot instruction is accepted. An instruction accepted in the same cycle as a redirect counts as accepted.
  - stall=0 and no redirect: accepted; if_valid=0, go to REQ.
- Only one bus transaction is outstanding at a time. inst_data_ok outside WAIT is ignored, which covers a stale response after a mid-transaction reset. inst_addr_ok outside REQ is ignored.
- Latency with no stall and bus addr_ok/data_ok each one cycle after request: REQ (addr_ok) -> WAIT (data_ok) -> OUT (accept). That gives a 3-cycle fetch-to-accept period.
- No combinational path from bus inputs to inst_req/inst_addr. if_* outputs are registered.

Test Plan:
1. Reset release, zero-wait bus (addr_ok in REQ, data_ok first WAIT cycle), stall=0:
   - Addresses BFC0_0000, BFC0_0004, BFC0_0008 are issued.
   - if_valid pulses each 3 cycles with matching if_pc/if_inst.
2. stall=1 for 5 cycles while in OUT with if_pc=BFC0_0004:
   - if_* held constant and inst_req=0 throughout.
   - Next request after stall drops is BFC0_0008.
3. jump=1, jump_addr=8000_0100 while WAIT with data_ok 2 cycles later:
   - Returned data is discarded and if_valid stays 0.
   - Next inst_addr=8000_0100.
4. jump and branch both pulsed in OUT, jump_addr=8000_0200, branch_addr=8000_0300:
   - if_valid=0 next cycle.
   - Next inst_addr=8000_0200.
5. Redirect in REQ with addr_ok held low 3 cycles:
   - inst_addr stays at the old pc until addr_ok.
   - That response is discarded; next request uses the target.
   - A second redirect before data_ok: the last target wins.
6. Reset asserted in WAIT, data_ok arrives one cycle after release:
   - Data is ignored and if_valid=0.
   - First request is RESET_PC.
   - pc=FFFF_FFFC sequential fetch wraps to 0000_0000.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a req/addr_ok/data_ok
// instruction bus, applies jump/branch redirects and holds the fetched word for ID.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
   parameter logic [31:0] FETCH_STEP = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch,
   input  logic        jump,
   input  logic [31:0] branch_addr,
   input  logic [31:0] jump_addr,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        discard_q, discard_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;

   logic        redirect;
   logic [31:0] target;

   assign redirect = jump | branch;
   assign target   = jump ? jump_addr : branch_addr;

   // Bus outputs depend only on registered state, never on bus inputs.
   assign inst_req  = (state_q == S_REQ);
   assign inst_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_inst   = if_inst_q;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path infers a latch.
      state_d    = state_q;
      pc_d       = pc_q;
      tgt_d      = tgt_q;
      discard_d  = discard_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (redirect) pc_d = target;
         end

         S_REQ: begin
            // The address stays put while requesting; the redirect is remembered instead.
            if (redirect) begin
               discard_d = 1'b1;
               tgt_d     = target;
            end
            if (inst_addr_ok) state_d = S_WAIT;
         end

         S_WAIT: begin
            if (inst_data_ok) begin
               if (discard_q || redirect) begin
                  pc_d      = redirect ? target : tgt_q;
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else begin
                  if_valid_d = 1'b1;
                  if_pc_d    = pc_q;
                  if_inst_d  = inst_rdata;
                  pc_d       = pc_q + FETCH_STEP;
                  state_d    = S_OUT;
               end
            end else if (redirect) begin
               discard_d = 1'b1;
               tgt_d     = target;
            end
         end

         S_OUT: begin
            if (redirect) begin
               if_valid_d = 1'b0;
               pc_d       = target;
               state_d    = S_REQ;
            end else if (!stall) begin
               if_valid_d = 1'b0;
               state_d    = S_REQ;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         tgt_q      <= '0;
         discard_q  <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         tgt_q      <= tgt_d;
         discard_q  <= discard_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end

endmodule
